// File: rtl/avalon_pio_pkg.sv
// Shared constants for the Avalon-MM PIO slave with edge capture.
package avalon_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd1;
  localparam logic [2:0] ADDR_OUT_RB   = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_OUT_SET  = 3'd4;
  localparam logic [2:0] ADDR_OUT_CLR  = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// Input synchroniser, previous-value register, arming counter
// and per-bit edge detector.
module pio_sync_edge
  import avalon_pio_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] sync_data,
  output logic [DATA_W-1:0] edge_pulse
);

  localparam logic [2:0] ARM_CYC = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][DATA_W-1:0] sync_q;
  logic [DATA_W-1:0] prev_q;
  logic [DATA_W-1:0] raw_edge;
  logic [2:0]        arm_cnt;
  logic              armed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Hold off capture until the chain holds real samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      arm_cnt <= '0;
    else if (!armed)
      arm_cnt <= arm_cnt + 3'd1;
  end

  assign armed     = (arm_cnt == ARM_CYC);
  assign sync_data = sync_q[SYNC_STAGES-1];

  always_comb begin
    raw_edge = sync_data & ~prev_q;
    case (EDGE_TYPE)
      EDGE_FALL: raw_edge = ~sync_data & prev_q;
      EDGE_ANY:  raw_edge = sync_data ^ prev_q;
      default:   raw_edge = sync_data & ~prev_q;
    endcase
  end

  assign edge_pulse = armed ? raw_edge : '0;

endmodule

// File: rtl/avalon_pio_irq.sv
// Avalon-MM PIO slave: output register with set/clear, synced
// inputs, edge capture; PIO_IRQ_EN adds IRQ_MASK and irq.
module avalon_pio_irq
  import avalon_pio_pkg::*;
#(
  parameter int               DATA_W      = 8,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = EDGE_RISE,
  parameter logic [DATA_W-1:0] RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] out_port,
  output logic              irq
);

  logic              wr;
  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] sync_data;
  logic [DATA_W-1:0] edge_pulse;
  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] cap_q, cap_clr;
  logic [DATA_W-1:0] mask_rd;
  logic [DATA_W-1:0] rd_sel;
  logic [31:0]       rd_word;
  logic              unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign wd           = writedata[DATA_W-1:0];
  assign unused_wdata = ^writedata;

  pio_sync_edge #(
    .DATA_W      (DATA_W),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync (
    .clk        (clk),
    .reset      (reset),
    .in_port    (in_port),
    .sync_data  (sync_data),
    .edge_pulse (edge_pulse)
  );

  always_comb begin
    out_d = out_q;
    if (wr) begin
      case (address)
        ADDR_DATA:    out_d = wd;
        ADDR_OUT_SET: out_d = out_q | wd;
        ADDR_OUT_CLR: out_d = out_q & ~wd;
        default:      out_d = out_q;
      endcase
    end
  end

  assign cap_clr =
    (wr && address == ADDR_EDGE_CAP) ? wd : '0;

  // New edges win over a same-cycle write-1-clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= RESET_VALUE;
      cap_q <= '0;
    end else begin
      out_q <= out_d;
      cap_q <= (cap_q & ~cap_clr) | edge_pulse;
    end
  end

`ifdef PIO_IRQ_EN
  logic [DATA_W-1:0] mask_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      mask_q <= '0;
    else if (wr && address == ADDR_IRQ_MASK)
      mask_q <= wd;
  end

  assign mask_rd = mask_q;
  assign irq     = |(cap_q & mask_q);
`else
  assign mask_rd = '0;
  assign irq     = 1'b0;
`endif

  always_comb begin
    case (address)
      ADDR_DATA:     rd_sel = sync_data;
      ADDR_IRQ_MASK: rd_sel = mask_rd;
      ADDR_OUT_RB:   rd_sel = out_q;
      ADDR_EDGE_CAP: rd_sel = cap_q;
      default:       rd_sel = '0;
    endcase
    rd_word             = '0;
    rd_word[DATA_W-1:0] = rd_sel;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      readdata <= '0;
    else
      readdata <= rd_word;
  end

  assign out_port = out_q;

endmodule

// File: tb/tb_avalon_pio_irq.sv
// Randomised and directed bench for avalon_pio_irq against a
// history-based reference model (rising and any-edge instances).
module tb_avalon_pio_irq;

  localparam int S = 2;
  localparam logic [7:0] RV = 8'hA5;
`ifdef PIO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk, reset;
  logic [2:0]  address;
  logic        chipselect, write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] rd_r, rd_a;
  logic [7:0]  out_r, out_a;
  logic        irq_r, irq_a;

  avalon_pio_irq #(
    .DATA_W(8), .SYNC_STAGES(S), .EDGE_TYPE(0), .RESET_VALUE(RV)
  ) dut_r (
    .clk(clk), .reset(reset), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd_r),
    .in_port(in_port), .out_port(out_r), .irq(irq_r)
  );

  avalon_pio_irq #(
    .DATA_W(8), .SYNC_STAGES(S), .EDGE_TYPE(2), .RESET_VALUE(RV)
  ) dut_a (
    .clk(clk), .reset(reset), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd_a),
    .in_port(in_port), .out_port(out_a), .irq(irq_a)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [7:0] m_out, m_mask, m_cr, m_ca, m_rdr, m_rda;
  logic [7:0] hist[$];
  int         n;

  function automatic logic m_irq(logic [7:0] cap);
    return IRQ_EN ? |(cap & m_mask) : 1'b0;
  endfunction

  task automatic model_reset();
    m_out  = RV;
    m_mask = 8'h00;
    m_cr   = 8'h00;
    m_ca   = 8'h00;
    m_rdr  = 8'h00;
    m_rda  = 8'h00;
    hist.delete();
    n = 0;
  endtask

  task automatic compare_all();
    chk("out_r", {24'h0, out_r}, {24'h0, m_out});
    chk("out_a", {24'h0, out_a}, {24'h0, m_out});
    chk("rd_r", rd_r, {24'h0, m_rdr});
    chk("rd_a", rd_a, {24'h0, m_rda});
    chk("irq_r", {31'h0, irq_r}, {31'h0, m_irq(m_cr)});
    chk("irq_a", {31'h0, irq_a}, {31'h0, m_irq(m_ca)});
  endtask

  // One clock edge: predict from current inputs, then compare.
  task automatic tick();
    logic [7:0] sy, pv, pr, pa, wd, clr, sel_r, sel_a;
    logic wr, armed;
    sy    = (n >= S) ? hist[n-S] : 8'h00;
    pv    = (n >= S + 1) ? hist[n-S-1] : 8'h00;
    armed = (n >= S + 1);
    pr    = armed ? (sy & ~pv) : 8'h00;
    pa    = armed ? (sy ^ pv) : 8'h00;
    wr    = chipselect && !write_n;
    wd    = writedata[7:0];
    case (address)
      3'd0: begin sel_r = sy; sel_a = sy; end
      3'd1: begin sel_r = m_mask; sel_a = m_mask; end
      3'd2: begin sel_r = m_out; sel_a = m_out; end
      3'd3: begin sel_r = m_cr; sel_a = m_ca; end
      default: begin sel_r = 8'h00; sel_a = 8'h00; end
    endcase
    m_rdr = sel_r;
    m_rda = sel_a;
    if (wr && address == 3'd0) m_out = wd;
    if (wr && address == 3'd4) m_out = m_out | wd;
    if (wr && address == 3'd5) m_out = m_out & ~wd;
    if (wr && address == 3'd1 && IRQ_EN) m_mask = wd;
    clr  = (wr && address == 3'd3) ? wd : 8'h00;
    m_cr = (m_cr & ~clr) | pr;
    m_ca = (m_ca & ~clr) | pa;
    hist.push_back(in_port);
    n++;
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic wr_reg(logic [2:0] a, logic [7:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = {$urandom_range(255, 0), 16'h0, d};
    tick();
    idle();
  endtask

  task automatic rd_reg(logic [2:0] a);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    tick();
    idle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_out_now", {24'h0, out_r}, {24'h0, RV});
    chk("rst_rd_now", rd_a, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_out_hold", {24'h0, out_a}, {24'h0, RV});
    chk("rst_irq", {31'h0, irq_r}, 32'h0);
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    in_port    = 8'hFF;
    model_reset();
    #2;
    do_reset();

    address = 3'd3;
    repeat (10) tick();
    rd_reg(3'd3);
    chk("cap_after_rst_r", rd_r, 32'h0);
    chk("cap_after_rst_a", rd_a, 32'h0);
    chk("irq_after_rst", {31'h0, irq_r}, 32'h0);

    wr_reg(3'd0, 8'h0F);
    chk("out_load", {24'h0, out_r}, 32'h0F);
    wr_reg(3'd4, 8'h30);
    chk("out_set", {24'h0, out_r}, 32'h3F);
    wr_reg(3'd5, 8'h05);
    chk("out_clr", {24'h0, out_r}, 32'h3A);
    rd_reg(3'd2);
    chk("out_rb", rd_r, 32'h3A);

    in_port = 8'h00;
    repeat (5) tick();
    wr_reg(3'd3, 8'hFF);
    wr_reg(3'd1, 8'h03);
    tick();

    in_port = 8'h01;
    tick();
    tick();
    chk("irq_early", {31'h0, irq_r}, 32'h0);
    tick();
    chk("irq_3edges", {31'h0, irq_r}, {31'h0, IRQ_EN});
    rd_reg(3'd3);
    chk("cap_bit0", rd_r, 32'h01);
    wr_reg(3'd3, 8'h01);
    chk("irq_cleared", {31'h0, irq_r}, 32'h0);

    in_port = 8'h03;
    tick();
    tick();
    wr_reg(3'd3, 8'h02);
    chk("set_wins_irq", {31'h0, irq_r}, {31'h0, IRQ_EN});
    rd_reg(3'd3);
    chk("set_wins_cap", rd_r, 32'h02);

    in_port = 8'h0B;
    tick();
    in_port = 8'h03;
    repeat (4) tick();
    rd_reg(3'd3);
    chk("glitch_any", rd_a, 32'h0A);
    rd_reg(3'd7);
    chk("rsvd_rd", rd_a, 32'h0);
    wr_reg(3'd7, 8'hFF);
    rd_reg(3'd2);
    chk("rsvd_wr_out", rd_r, 32'h3A);
    rd_reg(3'd3);
    chk("rsvd_wr_cap", rd_a, 32'h0A);

    wr_reg(3'd1, 8'hFF);
    rd_reg(3'd1);
    chk("mask_rb", rd_r, IRQ_EN ? 32'hFF : 32'h0);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99, 0) == 0) begin
        do_reset();
      end else begin
        address    = 3'($urandom_range(7, 0));
        chipselect = ($urandom_range(3, 0) != 0);
        write_n    = ($urandom_range(2, 0) != 0);
        writedata  = $urandom;
        if ($urandom_range(2, 0) == 0)
          in_port = in_port ^ 8'($urandom);
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
